// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the Wishbone classic master
//                bridge: bridge FSM state encoding, captured-request record
//                and the all-lanes byte-select constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_ADR_WIDTH = 32;
  localparam int WB_DAT_WIDTH = 32;
  localparam int WB_SEL_WIDTH = WB_DAT_WIDTH / 8;

  // Reads always fetch the full word; the core extracts the lanes it needs.
  localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_ALL = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  // Request as presented on the Wishbone side; field widths follow the
  // package widths above.
  typedef struct packed {
    logic [WB_ADR_WIDTH-1:0] adr;
    logic [WB_DAT_WIDTH-1:0] datwr;
    logic [WB_SEL_WIDTH-1:0] sel;
    logic                    we;
  } wb_req_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : wb_master_bridge
//  Description : Converts a core valid/ready request/response memory port
//                into a Wishbone classic master. One transaction in flight;
//                every Wishbone output comes straight from a flop.
//  Revision    : 1.0 - initial release
//
//  Optional feature macro:
//    WB_BRIDGE_TIMEOUT_EN - abort a bus cycle that has not been acknowledged
//                           within TIMEOUT_CYCLES cycles and return rsp_err=1.
//                           Undefined: the bridge waits for ack indefinitely
//                           and rsp_err is tied low.
//
//  Ports
//    clock, reset            : clock, synchronous active-high reset
//    req_valid/req_ready     : core request handshake
//    req_we/adr/dat/sel      : request attributes (sel used for writes only)
//    rsp_valid/rsp_ready     : core response handshake
//    rsp_dat, rsp_err        : read data (0 for writes), timeout abort flag
//    wb_cyc/stb/we/adr/      : Wishbone master outputs
//      datwr/sel
//    wb_datrd, wb_ack        : Wishbone slave return path
// ============================================================================
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int ADR_WIDTH      = WB_ADR_WIDTH,
  parameter int DAT_WIDTH      = WB_DAT_WIDTH,
  parameter int SEL_WIDTH      = WB_SEL_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  // core request
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADR_WIDTH-1:0] req_adr,
  input  logic [DAT_WIDTH-1:0] req_dat,
  input  logic [SEL_WIDTH-1:0] req_sel,
  // core response
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DAT_WIDTH-1:0] rsp_dat,
  output logic                 rsp_err,
  // Wishbone master
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [ADR_WIDTH-1:0] wb_adr,
  output logic [DAT_WIDTH-1:0] wb_datwr,
  output logic [SEL_WIDTH-1:0] wb_sel,
  input  logic [DAT_WIDTH-1:0] wb_datrd,
  input  logic                 wb_ack
);

  bridge_state_t          r_state,     w_state_nxt;
  wb_req_t                r_req,       w_req_nxt;
  logic                   r_cyc,       w_cyc_nxt;
  logic                   r_stb,       w_stb_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic [DAT_WIDTH-1:0]   r_rsp_dat,   w_rsp_dat_nxt;

`ifdef WB_BRIDGE_TIMEOUT_EN
  // At least 8 bits wide, wider if the configured limit needs it.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic             r_rsp_err, w_rsp_err_nxt;
  logic             w_tmo_expire;

  // The counter reads 0 in the first BUS cycle, so reaching LAST means the
  // cycle has been on the bus for TIMEOUT_CYCLES cycles.
  assign w_tmo_expire = (r_tmo_cnt == C_TMO_LAST);
  assign rsp_err      = r_rsp_err;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign rsp_err              = 1'b0;
`endif

  // Ready is a function of state only so the core never sees a combinational
  // path from its own valid back into ready.
  assign req_ready = (r_state == IDLE);

  assign wb_cyc    = r_cyc;
  assign wb_stb    = r_stb;
  assign wb_we     = r_req.we;
  assign wb_adr    = r_req.adr;
  assign wb_datwr  = r_req.datwr;
  assign wb_sel    = r_req.sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
`ifdef WB_BRIDGE_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_cyc       <= w_cyc_nxt;
      r_stb       <= w_stb_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
`ifdef WB_BRIDGE_TIMEOUT_EN
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_cyc_nxt       = r_cyc;
    w_stb_nxt       = r_stb;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
`ifdef WB_BRIDGE_TIMEOUT_EN
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_rsp_err_nxt   = r_rsp_err;
`endif

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_req_nxt.adr   = req_adr;
          w_req_nxt.datwr = req_dat;
          w_req_nxt.sel   = req_we ? req_sel : WB_SEL_ALL;
          w_req_nxt.we    = req_we;
          w_cyc_nxt       = 1'b1;
          w_stb_nxt       = 1'b1;
          w_state_nxt     = BUS;
`ifdef WB_BRIDGE_TIMEOUT_EN
          w_tmo_cnt_nxt   = '0;
`endif
        end
      end

      BUS: begin
        // An ack in the expiry cycle still completes normally.
        if (wb_ack) begin
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_req_nxt.we    = 1'b0;
          w_rsp_dat_nxt   = r_req.we ? '0 : wb_datrd;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RESP;
`ifdef WB_BRIDGE_TIMEOUT_EN
          w_rsp_err_nxt   = 1'b0;
`endif
        end
`ifdef WB_BRIDGE_TIMEOUT_EN
        else if (w_tmo_expire) begin
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_req_nxt.we    = 1'b0;
          w_rsp_dat_nxt   = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RESP;
        end else begin
          w_tmo_cnt_nxt   = r_tmo_cnt + 1'b1;
        end
`endif
      end

      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule : wb_master_bridge
`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_master_bridge
//  Description : Directed self-checking bench for wb_master_bridge. Expected
//                responses are queued when a request is issued and popped at
//                the response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_master_bridge;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_datwr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_datrd = '0;
  logic        wb_ack = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;
  exp_t sb[$];

  wb_master_bridge #(
    .ADR_WIDTH     (32),
    .DAT_WIDTH     (32),
    .SEL_WIDTH     (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_datwr (wb_datwr),
    .wb_sel   (wb_sel),
    .wb_datrd (wb_datrd),
    .wb_ack   (wb_ack)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic cyc, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    check({tag, ".cyc"}, 64'(wb_cyc), 64'(cyc));
    check({tag, ".stb"}, 64'(wb_stb), 64'(cyc));
    check({tag, ".we"},  64'(wb_we),  64'(we));
    check({tag, ".adr"}, 64'(wb_adr), 64'(adr));
    check({tag, ".dat"}, 64'(wb_datwr), 64'(dat));
    check({tag, ".sel"}, 64'(wb_sel), 64'(sel));
  endtask

  // Complete the response handshake and compare against the scoreboard head.
  task automatic handshake(input string tag);
    exp_t e;
    rsp_ready = 1'b1;
    check({tag, ".sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".rsp_dat"}, 64'(rsp_dat), 64'(e.dat));
      check({tag, ".rsp_err"}, 64'(rsp_err), 64'(e.err));
    end
    tick();
    rsp_ready = 1'b0;
    check({tag, ".post_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, ".post_ready"}, 64'(req_ready), 64'd1);
  endtask

  // One full transaction: request, 'waits' cycles before ack, 'bp' cycles of
  // response backpressure, then handshake.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int waits, input logic [31:0] ack_data, input int bp);
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdat;
    exp_sel  = we ? sel : 4'hF;
    exp_rdat = we ? 32'h0 : ack_data;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    sb.push_back('{dat: exp_rdat, err: 1'b0});
    check({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0; req_adr = 32'hFFFF_FFFF; req_dat = 32'h0BAD_0BAD; req_sel = 4'h0;
    check({tag, ".req_ready_bus"}, 64'(req_ready), 64'd0);
    check_wb({tag, ".bus0"}, 1'b1, we, adr, dat, exp_sel);
    for (int i = 0; i < waits; i++) begin
      tick();
      check_wb({tag, ".bus_hold"}, 1'b1, we, adr, dat, exp_sel);
      check({tag, ".no_rsp_yet"}, 64'(rsp_valid), 64'd0);
    end
    wb_ack = 1'b1; wb_datrd = ack_data;
    tick();
    wb_ack = 1'b0; wb_datrd = 32'h5555_AAAA;
    check({tag, ".cyc_drop"}, 64'(wb_cyc), 64'd0);
    check({tag, ".stb_drop"}, 64'(wb_stb), 64'd0);
    check({tag, ".we_drop"},  64'(wb_we),  64'd0);
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, ".bp_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, ".bp_dat"},   64'(rsp_dat),   64'(exp_rdat));
      check({tag, ".bp_ready"}, 64'(req_ready), 64'd0);
    end
    handshake(tag);
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b0;
    check("rst.state_ready", 64'(req_ready), 64'd1);
    check_wb("rst", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.rsp_dat",   64'(rsp_dat),   64'd0);
    check("rst.rsp_err",   64'(rsp_err),   64'd0);

    // Read, ack one cycle after stb, req_sel ignored for reads
    do_txn("read", 1'b0, 32'h0000_0100, 32'h1111_2222, 4'h3, 0, 32'hDEAD_BEEF, 0);

    // Write with three wait states; slave data on ack must not leak
    do_txn("write", 1'b1, 32'h0000_0204, 32'h1234_5678, 4'b0011, 3, 32'hCAFE_F00D, 0);

    // Response backpressure for five cycles
    do_txn("bp", 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1, 32'hA5A5_5A5A, 5);

`ifndef WB_BRIDGE_TIMEOUT_EN
    // Without the timeout the bridge waits as long as the slave needs
    do_txn("longwait", 1'b1, 32'h0000_0400, 32'h0F0F_F0F0, 4'b1100, 20, 32'h0, 1);
`endif

    // Reset asserted while in BUS
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_0500;
    tick();
    req_valid = 1'b0;
    check("rstbus.cyc_before", 64'(wb_cyc), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstbus.cyc",       64'(wb_cyc),    64'd0);
    check("rstbus.stb",       64'(wb_stb),    64'd0);
    check("rstbus.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstbus.req_ready", 64'(req_ready), 64'd1);
    wb_ack = 1'b1; wb_datrd = 32'h7777_7777;
    tick();
    wb_ack = 1'b0;
    check("lateack.rsp_valid", 64'(rsp_valid), 64'd0);
    check("lateack.cyc",       64'(wb_cyc),    64'd0);
    check("lateack.req_ready", 64'(req_ready), 64'd1);

    // Spurious acks in IDLE with no request
    wb_ack = 1'b1;
    tick(); tick();
    wb_ack = 1'b0;
    tick();
    check("spur.rsp_valid", 64'(rsp_valid), 64'd0);
    check("spur.req_ready", 64'(req_ready), 64'd1);
    check("spur.cyc",       64'(wb_cyc),    64'd0);

    // A normal transaction still works afterwards
    do_txn("after", 1'b0, 32'h0000_0600, 32'h0, 4'h0, 2, 32'h0123_4567, 2);

`ifdef WB_BRIDGE_TIMEOUT_EN
    // No ack: cyc stays up for exactly TMO cycles, then aborts with error
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_0700;
    sb.push_back('{dat: 32'h0, err: 1'b1});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      check("tmo.cyc_held", 64'(wb_cyc), 64'd1);
      check("tmo.no_rsp",   64'(rsp_valid), 64'd0);
      tick();
    end
    check("tmo.cyc_drop",  64'(wb_cyc),    64'd0);
    check("tmo.stb_drop",  64'(wb_stb),    64'd0);
    check("tmo.rsp_valid", 64'(rsp_valid), 64'd1);
    handshake("tmo");

    // Ack in the expiry cycle wins
    do_txn("tmo_ackwin", 1'b0, 32'h0000_0800, 32'h0, 4'h0, TMO - 1, 32'hBEEF_0001, 0);
`endif

    check("sb.drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_wb_master_bridge
`default_nettype wire
